// File: rtl/vscale_htif_pkg.sv
// Shared definitions for the host-side HTIF engine: engine states, CSR
// addresses of the tohost/fromhost mailboxes and the PCR data width.
package vscale_htif_pkg;

  localparam int HTIF_PCR_WIDTH = 64;
  localparam int CSR_ADDR_WIDTH = 12;

  // Must track vscale_csr_addr_map
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_TOHOST   = 12'h780;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_FROMHOST = 12'h781;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_CLR_REQ,
    ST_CLR_RESP,
    ST_FH_REQ,
    ST_FH_RESP,
    ST_DONE
  } htif_state_t;

endpackage

// File: rtl/vscale_htif_poll_timer.sv
// Reloadable down-counter that paces tohost polling. Reports expiry when the
// count has reached zero; it holds at zero until reloaded.
module vscale_htif_poll_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Load has priority over decrement; never wraps below zero
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/vscale_htif_host.sv
// Host-side HTIF engine: polls tohost over the PCR channel, clears it once a
// nonzero value shows up and reports pass/fail, optionally with a timeout.
// Optional feature macro: VSCALE_HTIF_FROMHOST_ACK_EN adds an acknowledge
// write of 1 to fromhost after the tohost clear, before DONE.
//
// state       | meaning
// ST_IDLE     | waiting for enable
// ST_WAIT     | poll interval countdown, timeout checked here
// ST_RD_REQ   | read request for tohost presented
// ST_RD_RESP  | waiting for tohost read data
// ST_CLR_REQ  | write of 0 to tohost presented
// ST_CLR_RESP | waiting for clear write response
// ST_FH_REQ   | write of 1 to fromhost presented (feature builds only)
// ST_FH_RESP  | waiting for fromhost write response (feature builds only)
// ST_DONE     | result held until reset
module vscale_htif_host
  import vscale_htif_pkg::*;
#(
  parameter int PCR_W         = HTIF_PCR_WIDTH,
  parameter int ADDR_W        = CSR_ADDR_WIDTH,
  parameter int POLL_INTERVAL = 64,
  parameter int CNT_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  max_cycles,
  output logic              htif_pcr_req_valid,
  input  logic              htif_pcr_req_ready,
  output logic              htif_pcr_req_rw,
  output logic [ADDR_W-1:0] htif_pcr_req_addr,
  output logic [PCR_W-1:0]  htif_pcr_req_data,
  input  logic              htif_pcr_resp_valid,
  output logic              htif_pcr_resp_ready,
  input  logic [PCR_W-1:0]  htif_pcr_resp_data,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [PCR_W-2:0]  fail_code,
  output logic [CNT_W-1:0]  cycle_count
);

  // POLL_INTERVAL-1 always fits in clog2(POLL_INTERVAL) bits
  localparam int TIMER_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_INTERVAL - 1);
  localparam logic [ADDR_W-1:0]  ADDR_TOHOST   = ADDR_W'(CSR_ADDR_TOHOST);
`ifdef VSCALE_HTIF_FROMHOST_ACK_EN
  localparam logic [ADDR_W-1:0]  ADDR_FROMHOST = ADDR_W'(CSR_ADDR_FROMHOST);
`endif

  htif_state_t state;

  logic req_fire;
  logic resp_fire;
  logic resp_zero;
  logic resp_one;
  logic timeout_hit;
  logic timer_load;
  logic timer_dec;
  logic timer_expired;

  assign req_fire    = htif_pcr_req_valid && htif_pcr_req_ready;
  assign resp_fire   = htif_pcr_resp_valid && htif_pcr_resp_ready;
  assign resp_zero   = (htif_pcr_resp_data == '0);
  assign resp_one    = (htif_pcr_resp_data == PCR_W'(1));
  assign timeout_hit = (max_cycles != '0) && (cycle_count >= max_cycles);

  assign timer_load = ((state == ST_IDLE) && enable) ||
                      ((state == ST_RD_RESP) && resp_fire && resp_zero);
  assign timer_dec  = (state == ST_WAIT) && !timer_expired;

  vscale_htif_poll_timer #(
    .WIDTH (TIMER_W)
  ) u_poll_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (TIMER_RELOAD),
    .dec        (timer_dec),
    .expired    (timer_expired)
  );

  // Engine FSM; request fields are only written when a request is launched,
  // so they stay stable until the core accepts it
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= ST_IDLE;
      htif_pcr_req_valid  <= 1'b0;
      htif_pcr_req_rw     <= 1'b0;
      htif_pcr_req_addr   <= '0;
      htif_pcr_req_data   <= '0;
      htif_pcr_resp_ready <= 1'b0;
      done                <= 1'b0;
      pass                <= 1'b0;
      timed_out           <= 1'b0;
      fail_code           <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (timeout_hit) begin
            state     <= ST_DONE;
            done      <= 1'b1;
            timed_out <= 1'b1;
            pass      <= 1'b0;
            fail_code <= '0;
          end else if (timer_expired) begin
            state              <= ST_RD_REQ;
            htif_pcr_req_valid <= 1'b1;
            htif_pcr_req_rw    <= 1'b0;
            htif_pcr_req_addr  <= ADDR_TOHOST;
            htif_pcr_req_data  <= '0;
          end
        end

        ST_RD_REQ: begin
          if (req_fire) begin
            state               <= ST_RD_RESP;
            htif_pcr_req_valid  <= 1'b0;
            htif_pcr_resp_ready <= 1'b1;
          end
        end

        ST_RD_RESP: begin
          if (resp_fire) begin
            htif_pcr_resp_ready <= 1'b0;
            if (resp_zero) begin
              state <= ST_WAIT;
            end else begin
              state              <= ST_CLR_REQ;
              pass               <= resp_one;
              fail_code          <= resp_one ? '0 : htif_pcr_resp_data[PCR_W-1:1];
              htif_pcr_req_valid <= 1'b1;
              htif_pcr_req_rw    <= 1'b1;
              htif_pcr_req_addr  <= ADDR_TOHOST;
              htif_pcr_req_data  <= '0;
            end
          end
        end

        ST_CLR_REQ: begin
          if (req_fire) begin
            state               <= ST_CLR_RESP;
            htif_pcr_req_valid  <= 1'b0;
            htif_pcr_resp_ready <= 1'b1;
          end
        end

        ST_CLR_RESP: begin
          if (resp_fire) begin
            htif_pcr_resp_ready <= 1'b0;
`ifdef VSCALE_HTIF_FROMHOST_ACK_EN
            state              <= ST_FH_REQ;
            htif_pcr_req_valid <= 1'b1;
            htif_pcr_req_rw    <= 1'b1;
            htif_pcr_req_addr  <= ADDR_FROMHOST;
            htif_pcr_req_data  <= PCR_W'(1);
`else
            state <= ST_DONE;
            done  <= 1'b1;
`endif
          end
        end

`ifdef VSCALE_HTIF_FROMHOST_ACK_EN
        ST_FH_REQ: begin
          if (req_fire) begin
            state               <= ST_FH_RESP;
            htif_pcr_req_valid  <= 1'b0;
            htif_pcr_resp_ready <= 1'b1;
          end
        end

        ST_FH_RESP: begin
          if (resp_fire) begin
            state               <= ST_DONE;
            htif_pcr_resp_ready <= 1'b0;
            done                <= 1'b1;
          end
        end
`endif

        ST_DONE: begin
        end

        default: begin
          state               <= ST_IDLE;
          htif_pcr_req_valid  <= 1'b0;
          htif_pcr_resp_ready <= 1'b0;
        end
      endcase
    end
  end

  // Run-length counter: active outside IDLE and DONE, saturates at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
    end else if ((state != ST_IDLE) && (state != ST_DONE) && (cycle_count != '1)) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vscale_htif_host.sv
// Bench for vscale_htif_host: a small core model answers the PCR channel,
// expected requests are queued per scenario and checked as they transfer.
module tb_vscale_htif_host;

  localparam int PCR_W  = 64;
  localparam int ADDR_W = 12;
  localparam int POLL   = 4;
  localparam int CNT_W  = 32;
`ifdef VSCALE_HTIF_FROMHOST_ACK_EN
  localparam int FH_EXTRA = 2;
`else
  localparam int FH_EXTRA = 0;
`endif

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [PCR_W-1:0]  data;
  } req_t;

  logic              clk;
  logic              reset;
  logic              enable;
  logic [CNT_W-1:0]  max_cycles;
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [PCR_W-1:0]  req_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [PCR_W-1:0]  resp_data;
  logic              done;
  logic              pass;
  logic              timed_out;
  logic [PCR_W-2:0]  fail_code;
  logic [CNT_W-1:0]  cycle_count;

  int errors = 0;
  int checks = 0;

  req_t             exp_q[$];
  logic [PCR_W-1:0] rd_vals[$];
  logic [CNT_W-1:0] xfer_cc[$];
  int               stall_cnt;
  logic             stall_rw;

  vscale_htif_host #(
    .PCR_W         (PCR_W),
    .ADDR_W        (ADDR_W),
    .POLL_INTERVAL (POLL),
    .CNT_W         (CNT_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .max_cycles          (max_cycles),
    .htif_pcr_req_valid  (req_valid),
    .htif_pcr_req_ready  (req_ready),
    .htif_pcr_req_rw     (req_rw),
    .htif_pcr_req_addr   (req_addr),
    .htif_pcr_req_data   (req_data),
    .htif_pcr_resp_valid (resp_valid),
    .htif_pcr_resp_ready (resp_ready),
    .htif_pcr_resp_data  (resp_data),
    .done                (done),
    .pass                (pass),
    .timed_out           (timed_out),
    .fail_code           (fail_code),
    .cycle_count         (cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Core model and scoreboard: transfers are judged at the negedge before
  // the edge that performs them; the response follows one cycle later
  logic             m_req_x;
  logic             m_resp_x;
  logic [PCR_W-1:0] m_data;
  req_t             m_exp;
  req_t             m_got;

  initial begin
    resp_valid = 1'b0;
    resp_data  = '0;
    req_ready  = 1'b1;
    forever begin
      @(negedge clk);
      m_req_x  = req_valid && req_ready;
      m_resp_x = resp_valid && resp_ready;
      if (req_valid && !req_ready && stall_cnt > 0 && req_rw == stall_rw)
        stall_cnt = stall_cnt - 1;
      if (m_req_x) begin
        m_got  = '{rw: req_rw, addr: req_addr, data: req_data};
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL sb_unexpected_req: got rw=%0b addr=%h data=%h, required no request",
                   req_rw, req_addr, req_data);
        end else begin
          m_exp = exp_q.pop_front();
          if (m_got !== m_exp) begin
            errors = errors + 1;
            $display("FAIL sb_req: got rw=%0b addr=%h data=%h, required rw=%0b addr=%h data=%h",
                     m_got.rw, m_got.addr, m_got.data, m_exp.rw, m_exp.addr, m_exp.data);
          end
        end
        xfer_cc.push_back(cycle_count);
        m_data = '0;
        if (!req_rw && rd_vals.size() > 0) m_data = rd_vals.pop_front();
      end
      @(posedge clk);
      #1;
      if (reset) begin
        resp_valid = 1'b0;
      end else begin
        if (m_resp_x) resp_valid = 1'b0;
        if (m_req_x) begin
          resp_valid = 1'b1;
          resp_data  = m_data;
        end
      end
      req_ready = !(stall_cnt > 0 && req_valid && req_rw == stall_rw);
    end
  end

  task automatic push_req(input logic rw, input logic [ADDR_W-1:0] addr, input logic [PCR_W-1:0] data);
    exp_q.push_back('{rw: rw, addr: addr, data: data});
  endtask

  // Clear write, plus the fromhost acknowledge in feature builds
  task automatic push_tail();
    push_req(1'b1, 12'h780, '0);
`ifdef VSCALE_HTIF_FROMHOST_ACK_EN
    push_req(1'b1, 12'h781, 64'd1);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    enable     = 1'b0;
    max_cycles = '0;
    stall_cnt  = 0;
    stall_rw   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    rd_vals.delete();
    xfer_cc.delete();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = done;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({req_valid, resp_ready, done, pass, timed_out} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid/rready/done/pass/to=%b, required 00000",
               {req_valid, resp_ready, done, pass, timed_out});
    end
    checks++;
    if ({req_rw, req_addr, req_data, fail_code, cycle_count} !== '0) begin
      errors++;
      $display("FAIL reset_regs: got rw=%0b addr=%h data=%h fc=%h cc=%0d, required all 0",
               req_rw, req_addr, req_data, fail_code, cycle_count);
    end
    for (int i = 0; i < 10; i++) @(negedge clk);
    checks++;
    if (req_valid !== 1'b0 || cycle_count !== '0) begin
      errors++;
      $display("FAIL idle_hold: got valid=%0b cc=%0d, required valid=0 cc=0", req_valid, cycle_count);
    end
  endtask

  task automatic test_pass_after_polls();
    bit ok;
    logic [CNT_W-1:0] cc_hold;
    do_reset();
    rd_vals.push_back(64'd0);
    rd_vals.push_back(64'd0);
    rd_vals.push_back(64'd1);
    for (int i = 0; i < 3; i++) push_req(1'b0, 12'h780, '0);
    push_tail();
    enable = 1'b1;
    wait_done(300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pass_done: got done=0 after budget, required done=1");
    end
    checks++;
    if ({pass, timed_out, fail_code} !== {1'b1, 1'b0, 63'd0}) begin
      errors++;
      $display("FAIL pass_result: got pass=%0b to=%0b fc=%h, required pass=1 to=0 fc=0",
               pass, timed_out, fail_code);
    end
    checks++;
    if (xfer_cc.size() < 3 || xfer_cc[0] !== 32'd4 || xfer_cc[1] !== 32'd10 || xfer_cc[2] !== 32'd16) begin
      errors++;
      $display("FAIL poll_cadence: got %0d transfers first at cc=%0d, required reads at cc 4,10,16",
               xfer_cc.size(), (xfer_cc.size() > 0) ? xfer_cc[0] : 32'd0);
    end
    checks++;
    if (cycle_count !== CNT_W'(20 + FH_EXTRA)) begin
      errors++;
      $display("FAIL pass_cycles: got cc=%0d, required %0d", cycle_count, 20 + FH_EXTRA);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pass_missing_req: got %0d requests outstanding, required 0", exp_q.size());
    end
    cc_hold = cycle_count;
    enable  = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || cycle_count !== cc_hold) begin
      errors++;
      $display("FAIL done_sticky: got done=%0b pass=%0b cc=%0d, required done=1 pass=1 cc=%0d",
               done, pass, cycle_count, cc_hold);
    end
  endtask

  task automatic test_fail_code();
    logic [PCR_W-1:0] vals [2];
    logic [PCR_W-2:0] codes[2];
    bit ok;
    vals[0]  = 64'd7;
    codes[0] = 63'd3;
    vals[1]  = 64'h8000_0000_0000_0005;
    codes[1] = 63'h4000_0000_0000_0002;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      rd_vals.push_back(vals[k]);
      push_req(1'b0, 12'h780, '0);
      push_tail();
      enable = 1'b1;
      wait_done(200, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL fail_done[%0d]: got done=0 after budget, required done=1", k);
      end
      checks++;
      if ({pass, timed_out, fail_code} !== {1'b0, 1'b0, codes[k]}) begin
        errors++;
        $display("FAIL fail_result[%0d]: got pass=%0b to=%0b fc=%h, required pass=0 to=0 fc=%h",
                 k, pass, timed_out, fail_code, codes[k]);
      end
      checks++;
      if (cycle_count !== CNT_W'(8 + FH_EXTRA) || exp_q.size() != 0) begin
        errors++;
        $display("FAIL fail_cycles[%0d]: got cc=%0d pending=%0d, required cc=%0d pending=0",
                 k, cycle_count, exp_q.size(), 8 + FH_EXTRA);
      end
    end
  endtask

  task automatic test_req_stall();
    req_t snap;
    int   n = 0;
    bit   ok;
    do_reset();
    stall_rw  = 1'b0;
    stall_cnt = 5;
    rd_vals.push_back(64'd1);
    push_req(1'b0, 12'h780, '0);
    push_tail();
    enable = 1'b1;
    while (!req_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    snap = '{rw: req_rw, addr: req_addr, data: req_data};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (req_valid !== 1'b1 || req_ready !== 1'b0 || resp_ready !== 1'b0 ||
          req_t'{rw: req_rw, addr: req_addr, data: req_data} !== snap ||
          snap !== req_t'{rw: 1'b0, addr: 12'h780, data: 64'd0}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%0b ready=%0b rready=%0b rw=%0b addr=%h data=%h, required 1 0 0 0 780 0",
                 i, req_valid, req_ready, resp_ready, req_rw, req_addr, req_data);
      end
      @(negedge clk);
    end
    wait_done(200, ok);
    checks++;
    if (!ok || pass !== 1'b1) begin
      errors++;
      $display("FAIL stall_done: got done=%0b pass=%0b, required done=1 pass=1", done, pass);
    end
    checks++;
    if (xfer_cc.size() != 2 + FH_EXTRA / 2 || xfer_cc[0] !== 32'd9) begin
      errors++;
      $display("FAIL stall_single: got %0d transfers first at cc=%0d, required %0d first at cc=9",
               xfer_cc.size(), (xfer_cc.size() > 0) ? xfer_cc[0] : 32'd0, 2 + FH_EXTRA / 2);
    end
    checks++;
    if (cycle_count !== CNT_W'(13 + FH_EXTRA)) begin
      errors++;
      $display("FAIL stall_cycles: got cc=%0d, required %0d", cycle_count, 13 + FH_EXTRA);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    max_cycles = 32'd20;
    for (int i = 0; i < 3; i++) push_req(1'b0, 12'h780, '0);
    enable = 1'b1;
    wait_done(300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_done: got done=0 after budget, required done=1");
    end
    checks++;
    if ({timed_out, pass, fail_code} !== {1'b1, 1'b0, 63'd0}) begin
      errors++;
      $display("FAIL timeout_result: got to=%0b pass=%0b fc=%h, required to=1 pass=0 fc=0",
               timed_out, pass, fail_code);
    end
    checks++;
    if (cycle_count !== 32'd21 || req_valid !== 1'b0 || resp_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle: got cc=%0d valid=%0b rready=%0b, required cc=21 valid=0 rready=0",
               cycle_count, req_valid, resp_ready);
    end
    checks++;
    if (exp_q.size() != 0 || xfer_cc.size() != 3) begin
      errors++;
      $display("FAIL timeout_reads: got %0d transfers, %0d pending, required 3 transfers 0 pending",
               xfer_cc.size(), exp_q.size());
    end
    for (int i = 0; i < 6; i++) @(negedge clk);
    checks++;
    if (cycle_count !== 32'd21 || done !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hold: got cc=%0d done=%0b, required cc=21 done=1", cycle_count, done);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    bit ok;
    do_reset();
    stall_rw  = 1'b1;
    stall_cnt = 1000;
    rd_vals.push_back(64'd1);
    push_req(1'b0, 12'h780, '0);
    push_req(1'b1, 12'h780, '0);
    enable = 1'b1;
    while (!(req_valid && req_rw) && n < 100) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 3; i++) @(negedge clk);
    checks++;
    if (req_valid !== 1'b1 || req_rw !== 1'b1 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_stalled: got valid=%0b rw=%0b ready=%0b, required 1 1 0",
               req_valid, req_rw, req_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (req_valid !== 1'b0 || done !== 1'b0 || cycle_count !== '0 || resp_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%0b done=%0b cc=%0d rready=%0b, required 0 0 0 0",
               req_valid, done, cycle_count, resp_ready);
    end
    enable    = 1'b0;
    stall_cnt = 0;
    reset     = 1'b0;
    exp_q.delete();
    rd_vals.delete();
    xfer_cc.delete();
    for (int i = 0; i < 8; i++) @(negedge clk);
    checks++;
    if (req_valid !== 1'b0 || cycle_count !== '0) begin
      errors++;
      $display("FAIL post_reset_idle: got valid=%0b cc=%0d, required 0 0", req_valid, cycle_count);
    end
    rd_vals.push_back(64'd1);
    push_req(1'b0, 12'h780, '0);
    push_tail();
    enable = 1'b1;
    wait_done(200, ok);
    checks++;
    if (!ok || pass !== 1'b1 || cycle_count !== CNT_W'(8 + FH_EXTRA) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rerun: got done=%0b pass=%0b cc=%0d pending=%0d, required 1 1 %0d 0",
               done, pass, cycle_count, exp_q.size(), 8 + FH_EXTRA);
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    max_cycles = '0;
    stall_cnt  = 0;
    stall_rw   = 1'b0;
    test_reset();
    test_pass_after_polls();
    test_fail_code();
    test_req_stall();
    test_timeout();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vscale_htif_host.md
Name: vscale_htif_host

Overview:
- Synthesizable host-side HTIF engine.
- Drives the core's htif_pcr_req channel and consumes htif_pcr_resp, the initiator end of the interface the core answers.
- Periodically reads CSR tohost and decodes pass/fail (1 = pass, else code = value>>1).
- Clears tohost and reports status.
- Lets FPGA/standalone builds run riscv-tests without a simulator bench.

Parameters:
- PCR_W, 64, HTIF PCR data width (equals HTIF_PCR_WIDTH).
- ADDR_W, 12, CSR address width.
- POLL_INTERVAL, 64, idle cycles between tohost reads; must be >= 1.
- CNT_W, 32, width of cycle counter and max_cycles.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- enable  in  1  start polling; level-sensitive, sampled in IDLE only
- max_cycles  in  CNT_W  timeout limit; 0 = no timeout
- htif_pcr_req_valid  out  1  request valid
- htif_pcr_req_ready  in  1  core accepts request
- htif_pcr_req_rw  out  1  1 = write, 0 = read
- htif_pcr_req_addr  out  ADDR_W  CSR address
- htif_pcr_req_data  out  PCR_W  write data
- htif_pcr_resp_valid  in  1  response valid
- htif_pcr_resp_ready  out  1  engine accepts response
- htif_pcr_resp_data  in  PCR_W  read data
- done  out  1  sticky test-finished flag
- pass  out  1  valid when done; 1 = tohost was 1
- timed_out  out  1  valid when done; timeout ended the run
- fail_code  out  PCR_W-1  tohost>>1 when failed, else 0
- cycle_count  out  CNT_W  cycles since leaving IDLE

Behaviour:
- Reset (synchronous, active-high, overrides all): state=IDLE; all outputs 0; poll timer=0; cycle_count=0.
- Reset asserted mid-handshake drops req_valid the next cycle; no completion is required.
- Request addresses: tohost = 12'h780, fromhost = 12'h781.
- States:
  - IDLE -> WAIT when enable=1. Timer loads POLL_INTERVAL-1.
  - WAIT: timer decrements by 1 per cycle. At 0 -> RD_REQ.
  - RD_REQ: req_valid=1, rw=0, addr=tohost, data=0. Transfer occurs on a cycle with valid&ready; then -> RD_RESP.
  - RD_RESP: resp_ready=1. On resp_valid, capture data:
    - 0 -> WAIT, timer reloaded.
    - nonzero -> CLR_REQ. Latch pass=(data==1), fail_code=(data==1)?0:data>>1.
  - CLR_REQ: req_valid=1, rw=1, addr=tohost, data=0. -> CLR_RESP on transfer.
  - CLR_RESP: resp_ready=1. On resp_valid -> DONE (response data ignored).
  - DONE: done=1. pass/fail_code/timed_out held. Leaves only on reset.
- Handshake rules:
  - Once req_valid rises, valid, rw, addr and data are held stable until ready.
  - resp_ready=1 only in *_RESP states; responses arriving elsewhere are not consumed.
  - At most one outstanding request.
  - A response in the same cycle as its request acceptance is not possible; the engine waits at least 1 cycle.
- Cycle counter:
  - Increments every cycle outside IDLE and DONE.
  - Saturates at all-ones (no wrap).
- Timeout:
  - Condition: max_cycles!=0 and cycle_count>=max_cycles.
  - Acted on only in WAIT: -> DONE with timed_out=1, pass=0, fail_code=0.
  - In other states the pending transaction completes first; timeout is checked on the next WAIT entry.
  - A nonzero tohost read in the same cycle the timeout condition becomes true takes precedence; timed_out stays 0.
- enable deasserted after leaving IDLE has no effect.

Optional Feature:
- Macro VSCALE_HTIF_FROMHOST_ACK_EN.
- Defined: after CLR_RESP, add FH_REQ/FH_RESP states.
  - FH_REQ writes fromhost (12'h781) with data=1, same handshake rules.
  - DONE is entered only after FH_RESP completes, so latency from tohost detection to done grows by the extra write handshake.
- Undefined: CLR_RESP -> DONE directly; fromhost is never written.

Decomposition:
- Package vscale_htif_pkg holds:
  - state enum (IDLE, WAIT, RD_REQ, RD_RESP, CLR_REQ, CLR_RESP, FH_REQ, FH_RESP, DONE);
  - CSR address constants TOHOST/FROMHOST (values matching vscale_csr_addr_map);
  - PCR width constant.
- One sub-module: vscale_htif_poll_timer, a reloadable down-counter with load/expired outputs.

Test Plan:
1. Core responds with tohost=0 twice then 1, ready always 1, POLL_INTERVAL=4 -> reads at the 4-cycle cadence; one write of 0 to 12'h780; done=1, pass=1, fail_code=0.
2. tohost read returns 7 -> clear write issued; done=1, pass=0, fail_code=3.
3. req_ready held 0 for 5 cycles during RD_REQ -> valid/rw/addr/data stable all 5 cycles; a single transfer occurs.
4. max_cycles=20, tohost always 0 -> done=1, timed_out=1 on the first WAIT cycle with cycle_count>=20; no request left dangling.
5. Reset asserted while CLR_REQ is stalled -> next cycle req_valid=0, done=0, state IDLE; re-enable gives a normal run.
6. With VSCALE_HTIF_FROMHOST_ACK_EN, tohost=1 -> write 0 to 12'h780 then write 1 to 12'h781; done only after the second response.
